// File: rtl/if_id_skid_if.sv
// Handshake bundle between fetch, the IF/ID skid register and decode.
// The slave modport is the pipeline register; master is the surrounding stages.
interface if_id_skid_if #(
  parameter int unsigned PC_W   = 32,
  parameter int unsigned INST_W = 32,
  parameter int unsigned CNT_W  = 16
);
  logic              if_valid;
  logic              if_ready;
  logic [PC_W-1:0]   if_pc;
  logic [INST_W-1:0] if_inst;
  logic              flush;
  logic              id_valid;
  logic              id_ready;
  logic [PC_W-1:0]   id_pc;
  logic [INST_W-1:0] id_inst;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output if_valid, if_pc, if_inst, flush, id_ready,
    input  if_ready, id_valid, id_pc, id_inst, stall_cnt
  );

  modport slave (
    input  if_valid, if_pc, if_inst, flush, id_ready,
    output if_ready, id_valid, id_pc, id_inst, stall_cnt
  );
endinterface

// File: rtl/if_id_skid.sv
// IF/ID pipeline register with a 2-entry skid buffer, flush-to-bubble and a
// saturating stall counter. if_ready comes straight from state (no id_ready path).
module if_id_skid #(
  parameter int unsigned       PC_W     = 32,
  parameter int unsigned       INST_W   = 32,
  parameter logic [INST_W-1:0] NOP_INST = '0,
  parameter int unsigned       CNT_W    = 16
) (
  input logic         clk,
  input logic         rst,
  if_id_skid_if.slave bus
);

  // Encoding is {m_full, s_full}; ORPHAN is unreachable and recovers to EMPTY.
  typedef enum logic [1:0] {
    EMPTY  = 2'b00,
    ORPHAN = 2'b01,
    ONE    = 2'b10,
    TWO    = 2'b11
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [PC_W-1:0]   r_m_pc;
  logic [INST_W-1:0] r_m_inst;
  logic [PC_W-1:0]   r_s_pc;
  logic [INST_W-1:0] r_s_inst;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic w_m_full;
  logic w_s_full;
  logic w_accept;
  logic w_take;
  logic w_load_m_in;
  logic w_load_m_s;
  logic w_load_s;
  logic w_clr_s;

  assign w_m_full = r_state[1];
  assign w_s_full = r_state[0];
  assign w_accept = bus.if_valid && !w_s_full;
  assign w_take   = w_m_full && bus.id_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_load_m_in = 1'b0;
    w_load_m_s  = 1'b0;
    w_load_s    = 1'b0;
    w_clr_s     = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_accept) begin
          w_state_nxt = ONE;
          w_load_m_in = 1'b1;
        end
      end
      ONE: begin
        if (w_accept && w_take) begin
          w_load_m_in = 1'b1;
        end else if (w_accept) begin
          w_state_nxt = TWO;
          w_load_s    = 1'b1;
        end else if (w_take) begin
          w_state_nxt = EMPTY;
        end
      end
      TWO: begin
        if (w_take) begin
          w_state_nxt = ONE;
          w_load_m_s  = 1'b1;
          w_clr_s     = 1'b1;
        end
      end
      ORPHAN: begin
        w_state_nxt = EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= EMPTY;
      r_m_pc      <= '0;
      r_m_inst    <= NOP_INST;
      r_s_pc      <= '0;
      r_s_inst    <= NOP_INST;
      r_stall_cnt <= '0;
    end else if (bus.flush) begin
      // Stall counter deliberately untouched: only reset clears it.
      r_state  <= EMPTY;
      r_m_pc   <= '0;
      r_m_inst <= NOP_INST;
      r_s_pc   <= '0;
      r_s_inst <= NOP_INST;
    end else begin
      r_state <= w_state_nxt;
      if (w_load_m_in) begin
        r_m_pc   <= bus.if_pc;
        r_m_inst <= bus.if_inst;
      end else if (w_load_m_s) begin
        r_m_pc   <= r_s_pc;
        r_m_inst <= r_s_inst;
      end
      if (w_load_s) begin
        r_s_pc   <= bus.if_pc;
        r_s_inst <= bus.if_inst;
      end else if (w_clr_s) begin
        r_s_pc   <= '0;
        r_s_inst <= NOP_INST;
      end
      if (w_m_full && !bus.id_ready && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.if_ready  = !w_s_full;
  assign bus.id_valid  = w_m_full;
  assign bus.id_pc     = w_m_full ? r_m_pc : '0;
  assign bus.id_inst   = w_m_full ? r_m_inst : NOP_INST;
  assign bus.stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_if_id_skid.sv
// Bench for if_id_skid: directed scenarios plus random traffic, checked against
// a queue-based model of an in-order 2-deep buffer with a saturating stall counter.
module tb_if_id_skid;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rst4 = 1'b0;
  always #5 clk = ~clk;

  if_id_skid_if #(.PC_W(32), .INST_W(32), .CNT_W(16)) bus ();
  if_id_skid_if #(.PC_W(32), .INST_W(32), .CNT_W(4))  sbus ();

  if_id_skid #(.PC_W(32), .INST_W(32), .NOP_INST(NOP), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  if_id_skid #(.PC_W(32), .INST_W(32), .NOP_INST(NOP), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst4), .bus(sbus)
  );

  int unsigned total = 0;
  int unsigned bad = 0;

  logic [63:0] mq[$];
  logic [15:0] mcnt = '0;

  function automatic logic [81:0] exp_tuple();
    logic        v;
    logic [31:0] p;
    logic [31:0] i;
    v = (mq.size() > 0);
    p = v ? mq[0][63:32] : 32'h0;
    i = v ? mq[0][31:0] : NOP;
    return {v, (mq.size() < 2), p, i, mcnt};
  endfunction

  function automatic logic [81:0] got_tuple();
    return {bus.id_valid, bus.if_ready, bus.id_pc, bus.id_inst, bus.stall_cnt};
  endfunction

  // Advance one clock edge, updating the model from the inputs seen at that edge.
  task automatic tick();
    logic acc;
    logic tk;
    acc = bus.if_valid && (mq.size() < 2);
    tk  = (mq.size() > 0) && bus.id_ready;
    if (!rst) begin
      mq.delete();
      mcnt = '0;
    end else if (bus.flush) begin
      mq.delete();
    end else begin
      if ((mq.size() > 0) && !bus.id_ready && (mcnt != 16'hFFFF)) mcnt = mcnt + 16'd1;
      if (tk) void'(mq.pop_front());
      if (acc) mq.push_back({bus.if_pc, bus.if_inst});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; rst4 = 1'b0;
    bus.if_valid = 1'b1; bus.if_pc = 32'h100; bus.if_inst = 32'hDEAD_BEEF;
    bus.id_ready = 1'b0; bus.flush = 1'b0;
    sbus.if_valid = 1'b0; sbus.if_pc = '0; sbus.if_inst = '0;
    sbus.id_ready = 1'b1; sbus.flush = 1'b0;
    tick();
    tick();
    total++;
    if (got_tuple() !== {1'b0, 1'b1, 32'h0, NOP, 16'h0}) begin
      bad++;
      $display("FAIL reset: got=%h exp=%h", got_tuple(), {1'b0, 1'b1, 32'h0, NOP, 16'h0});
    end
    rst = 1'b1; rst4 = 1'b1;
    bus.if_valid = 1'b0;
    tick();
  endtask

  task automatic test_streaming();
    bus.id_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.if_valid = (i < 4);
      bus.if_pc    = 32'(4 * i);
      bus.if_inst  = 32'hA0 + 32'(i);
      tick();
      total++;
      if (got_tuple() !== exp_tuple()) begin
        bad++;
        $display("FAIL stream_model[%0d]: got=%h exp=%h", i, got_tuple(), exp_tuple());
      end
      if (i < 4) begin
        total++;
        if ({bus.id_valid, bus.id_pc, bus.id_inst} !== {1'b1, 32'(4 * i), 32'hA0 + 32'(i)}) begin
          bad++;
          $display("FAIL stream_out[%0d]: got=%b/%h/%h exp=1/%h/%h", i, bus.id_valid,
                   bus.id_pc, bus.id_inst, 32'(4 * i), 32'hA0 + 32'(i));
        end
      end
    end
    bus.if_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    logic [31:0] pcs[3];
    int unsigned idx;
    pcs[0] = 32'h10; pcs[1] = 32'h14; pcs[2] = 32'h18;
    idx = 0;
    for (int c = 0; c < 9; c++) begin
      bus.if_valid = (idx < 3);
      if (idx < 3) begin
        bus.if_pc   = pcs[idx];
        bus.if_inst = 32'hB0 + idx;
      end
      bus.id_ready = !(c >= 1 && c <= 3);
      if (idx < 3 && mq.size() < 2) idx++;
      tick();
      total++;
      if (got_tuple() !== exp_tuple()) begin
        bad++;
        $display("FAIL bp_model[%0d]: got=%h exp=%h", c, got_tuple(), exp_tuple());
      end
      if (c == 3) begin
        total++;
        if ({bus.if_ready, bus.id_pc, bus.stall_cnt} !== {1'b0, 32'h10, 16'd3}) begin
          bad++;
          $display("FAIL bp_stalled: got ready=%b pc=%h cnt=%0d exp ready=0 pc=10 cnt=3",
                   bus.if_ready, bus.id_pc, bus.stall_cnt);
        end
      end
      if (c == 4 || c == 5) begin
        total++;
        if (bus.id_pc !== pcs[c - 3]) begin
          bad++;
          $display("FAIL bp_order[%0d]: got=%h exp=%h", c, bus.id_pc, pcs[c - 3]);
        end
      end
    end
    total++;
    if (bus.stall_cnt !== 16'd3) begin
      bad++;
      $display("FAIL bp_cnt: got=%0d exp=3", bus.stall_cnt);
    end
  endtask

  task automatic test_flush_two();
    bus.id_ready = 1'b0;
    bus.if_valid = 1'b1; bus.if_pc = 32'h20; bus.if_inst = 32'hC20;
    tick();
    bus.if_pc = 32'h24; bus.if_inst = 32'hC24;
    tick();
    total++;
    if ({bus.id_pc, bus.if_ready} !== {32'h20, 1'b0}) begin
      bad++;
      $display("FAIL flush_setup: got pc=%h ready=%b exp pc=20 ready=0", bus.id_pc, bus.if_ready);
    end
    bus.if_pc = 32'h28; bus.if_inst = 32'hC28; bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0; bus.if_valid = 1'b0; bus.id_ready = 1'b1;
    total++;
    if ({bus.id_valid, bus.if_ready, bus.id_pc, bus.id_inst} !== {1'b0, 1'b1, 32'h0, NOP}) begin
      bad++;
      $display("FAIL flush_bubble: got=%b/%b/%h/%h exp=0/1/0/%h", bus.id_valid, bus.if_ready,
               bus.id_pc, bus.id_inst, NOP);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (got_tuple() !== exp_tuple() || bus.id_valid !== 1'b0) begin
        bad++;
        $display("FAIL flush_after[%0d]: got=%h exp=%h", i, got_tuple(), exp_tuple());
      end
    end
  endtask

  task automatic test_reset_mid();
    bus.id_ready = 1'b0;
    bus.if_valid = 1'b1; bus.if_pc = 32'h30; bus.if_inst = 32'hE30;
    tick();
    bus.if_pc = 32'h34; bus.if_inst = 32'hE34;
    tick();
    bus.if_pc = 32'h38; bus.if_inst = 32'hE38;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    total++;
    if (got_tuple() !== {1'b0, 1'b1, 32'h0, NOP, 16'h0}) begin
      bad++;
      $display("FAIL rstmid: got=%h exp=%h", got_tuple(), {1'b0, 1'b1, 32'h0, NOP, 16'h0});
    end
    bus.if_pc = 32'h40; bus.if_inst = 32'hE40; bus.id_ready = 1'b1;
    tick();
    bus.if_valid = 1'b0;
    total++;
    if ({bus.id_valid, bus.id_pc, bus.id_inst} !== {1'b1, 32'h40, 32'hE40}) begin
      bad++;
      $display("FAIL rstmid_latency: got=%b/%h/%h exp=1/40/e40", bus.id_valid, bus.id_pc, bus.id_inst);
    end
    tick();
  endtask

  task automatic test_saturation();
    logic [3:0] e;
    bus.if_valid = 1'b0; bus.id_ready = 1'b1;
    sbus.if_valid = 1'b1; sbus.if_pc = 32'h50; sbus.if_inst = 32'hD0; sbus.id_ready = 1'b0;
    tick();
    sbus.if_valid = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      e = 4'((n < 15) ? n : 15);
      total++;
      if ({sbus.id_valid, sbus.stall_cnt} !== {1'b1, e}) begin
        bad++;
        $display("FAIL sat[%0d]: got valid=%b cnt=%0d exp valid=1 cnt=%0d", n, sbus.id_valid,
                 sbus.stall_cnt, e);
      end
    end
    sbus.flush = 1'b1;
    tick();
    sbus.flush = 1'b0;
    total++;
    if ({sbus.id_valid, sbus.stall_cnt} !== {1'b0, 4'd15}) begin
      bad++;
      $display("FAIL sat_flush: got valid=%b cnt=%0d exp valid=0 cnt=15", sbus.id_valid, sbus.stall_cnt);
    end
    rst4 = 1'b0;
    tick();
    rst4 = 1'b1;
    total++;
    if (sbus.stall_cnt !== 4'd0) begin
      bad++;
      $display("FAIL sat_reset: got=%0d exp=0", sbus.stall_cnt);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      bus.if_valid = ($urandom_range(0, 3) != 0);
      bus.if_pc    = $urandom;
      bus.if_inst  = $urandom;
      bus.id_ready = ($urandom_range(0, 2) != 0);
      bus.flush    = ($urandom_range(0, 15) == 0);
      tick();
      total++;
      if (got_tuple() !== exp_tuple()) begin
        bad++;
        $display("FAIL random[%0d]: got=%h exp=%h", c, got_tuple(), exp_tuple());
      end
    end
    bus.flush = 1'b0;
    bus.if_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush_two();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
